frame_serializer: RTL and testbench
===================================

FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 Parameter: GAP_CYCLES, default 0, number of idle cycles inserted after each frame before the next frame is accepted (0..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 resetN  input  1  reset; asynchronous and active-low.
REQ-004 frame_in  input  538  framed word from the framer: {data[511:0], msg_counter[7:0], timer[7:0], auth_tag[7:0], state_bits[1:0]}.
REQ-005 frame_valid  input  1  frame_in is valid.
REQ-006 frame_ready  output  1  serializer can capture a frame this cycle.
REQ-007 tx_data  output  8  current output byte.
REQ-008 tx_valid  output  1  tx_data is valid.
REQ-009 tx_ready  input  1  downstream accepts tx_data this cycle.
REQ-010 tx_sof  output  1  the current byte is the first byte of a frame.
REQ-011 tx_eof  output  1  the current byte is the last byte of a frame.
REQ-012 busy  output  1  a frame is being serialized (state other than IDLE).
REQ-013 frame_cnt  output  16  count of completely transmitted frames.

Function
REQ-014 FSM states SHALL be IDLE, SEND, CRC (CRC only with the macro) and GAP.
REQ-015 frame_ready SHALL be 1 only in IDLE.
REQ-016 A frame SHALL be captured into an internal 538-bit register when frame_valid && frame_ready; the FSM then moves to SEND and tx_valid rises in the following cycle (1-cycle latency).
REQ-017 A frame SHALL be sent as 68 bytes, MSB first: byte k = frame[537-8k -: 8] for k = 0..66, and byte 67 = {frame[1:0], 6'b0}.
REQ-018 A byte SHALL advance only on tx_valid && tx_ready; while tx_ready=0, tx_data, tx_sof and tx_eof SHALL be held stable.
REQ-019 tx_sof SHALL be 1 on byte 0 only; tx_eof SHALL be 1 on the last byte of the frame (byte 67, or the CRC byte when enabled).
REQ-020 The byte index SHALL be a 7-bit counter that clears to 0 on each capture and never exceeds 68.
REQ-021 When the last byte is accepted, frame_cnt SHALL increment, wrapping from 0xFFFF to 0x0000, and the FSM SHALL enter GAP if GAP_CYCLES>0, otherwise IDLE.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles, with tx_valid=0 and frame_ready=0, and then return to IDLE.
REQ-023 frame_valid asserted outside IDLE SHALL be ignored, and the captured frame SHALL be unaffected.
REQ-024 Back-to-back frames with GAP_CYCLES=0 SHALL have exactly one idle cycle (the IDLE capture cycle) between the eof byte and the next sof byte.

Reset
REQ-025 While resetN=0, all outputs SHALL be forced immediately: tx_valid=0, tx_data=0, tx_sof=0, tx_eof=0, busy=0, frame_cnt=0, FSM=IDLE, so frame_ready=1.
REQ-026 Reset in mid-frame SHALL discard the frame; no remaining bytes are emitted after release.

Configuration
REQ-027 Macro FRAME_SERIALIZER_CRC_EN: when defined, a 69th byte SHALL follow byte 67, carrying the CRC-8 (polynomial 0x07, init 0x00, no reflection, no final XOR) over bytes 0..67 as transmitted, with tx_eof set on it.
REQ-028 Without FRAME_SERIALIZER_CRC_EN, the CRC state and logic SHALL be absent and frames are exactly 68 bytes.

Structure
REQ-029 Package frame_pkg SHALL hold: FRAME_W=538, BYTE_W=8, NUM_BYTES=68, the FSM state enum, and CRC8_POLY=8'h07.
REQ-030 Sub-module frame_crc8 SHALL hold the CRC-8 byte update: current crc and data byte in, next crc out, combinational; instantiated only under the macro.

Verification
REQ-031 Reset: hold resetN=0 with clk running -> tx_valid=0, frame_cnt=0, frame_ready=1; assert resetN=0 asynchronously between edges -> outputs clear without waiting for a clk edge.
REQ-032 Single frame, frame_in={512'h2AA, 8'hCC, 8'h33, 8'hF0, 2'b10}, tx_ready=1 -> bytes 0..61=0x00, 62=0x02, 63=0xAA, 64=0xCC, 65=0x33, 66=0xF0, 67=0x80; sof on byte 0, eof on byte 67; frame_cnt=1.
REQ-033 Backpressure: tx_ready=0 for 3 cycles at byte 5 -> tx_data stays at byte 5 and no byte is lost or duplicated; total accepted bytes=68.
REQ-034 frame_valid pulsed with a different frame at byte 20 -> frame_ready=0 and the original frame completes unchanged; with GAP_CYCLES=4, exactly 4 cycles of frame_ready=0 follow eof.
REQ-035 resetN pulsed low at byte 30 -> tx_valid=0 at once; after release the next captured frame starts at byte 0 with sof.
REQ-036 With FRAME_SERIALIZER_CRC_EN: all-zero frame -> 69 bytes, last byte 0x00 with eof; the REQ-032 frame -> byte 68 equals the frame_pkg-based software CRC-8 model.

Source files
------------

// File: rtl/frame_pkg.sv
// frame_pkg: shared constants, FSM state encoding and the CRC-8 byte
// update used by the frame serializer.
// Optional feature macro: FRAME_SERIALIZER_CRC_EN (appends a CRC-8 byte).
package frame_pkg;

    localparam int FRAME_W   = 538;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 68;

    // Frame padded on the right to a whole number of bytes (68 * 8 = 544).
    localparam int PAD_W     = NUM_BYTES * BYTE_W;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CRC  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // One byte of CRC-8, MSB first, no reflection.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc,
                                               input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < BYTE_W; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_crc8.sv
// frame_crc8: combinational CRC-8 byte update (poly 0x07, init handled by
// the caller). Only instantiated when FRAME_SERIALIZER_CRC_EN is defined.
module frame_crc8
    import frame_pkg::*;
(
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);

    // Next CRC value after absorbing one data byte.
    always_comb begin
        crc_next = crc8_update(crc, data);
    end

endmodule

// File: rtl/frame_serializer.sv
// frame_serializer: captures a 538-bit frame and emits it as 68 bytes
// (MSB first, last byte left-aligned 2 bits) on a valid/ready byte stream,
// followed by an optional idle gap of GAP_CYCLES cycles.
// Optional feature macro: FRAME_SERIALIZER_CRC_EN appends a 69th byte
// carrying CRC-8 over the 68 transmitted bytes.
module frame_serializer
    import frame_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               tx_sof,
    output logic               tx_eof,
    output logic               busy,
    output logic [15:0]        frame_cnt
);

    localparam logic [6:0] LAST_IDX = 7'(NUM_BYTES - 1);
    localparam logic [7:0] GAP_INIT = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam state_e     AFTER_FRAME = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_e                             state;
    logic [FRAME_W-1:0]                 frame_q;
    logic [6:0]                         byte_idx;
    logic [6:0]                         sel_idx;
    logic [6:0]                         rev_idx;
    logic [7:0]                         gap_cnt;
    logic [NUM_BYTES-1:0][BYTE_W-1:0]   frame_bytes;
    logic                               capture;
    logic                               byte_accept;
    logic                               send_accept;
    logic                               at_last;
    logic                               frame_done;

    // Byte view of the captured frame: element NUM_BYTES-1 is byte 0.
    assign frame_bytes = {frame_q, {(PAD_W - FRAME_W){1'b0}}};

    // The index can reach NUM_BYTES while the CRC byte is out; clamp it
    // so the frame-byte mux never selects past the array.
    assign sel_idx = (byte_idx > LAST_IDX) ? LAST_IDX : byte_idx;
    assign rev_idx = LAST_IDX - sel_idx;

    assign frame_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign capture     = frame_ready && frame_valid;
    assign byte_accept = tx_valid && tx_ready;
    assign send_accept = byte_accept && (state == ST_SEND);
    assign at_last     = (byte_idx == LAST_IDX);
    assign frame_done  = byte_accept && tx_eof;

`ifdef FRAME_SERIALIZER_CRC_EN
    logic [7:0] crc_q;
    logic [7:0] crc_next;

    frame_crc8 u_crc8 (
        .crc      (crc_q),
        .data     (tx_data),
        .crc_next (crc_next)
    );

    // Running CRC over the bytes actually accepted downstream.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            crc_q <= 8'd0;
        end else if (capture) begin
            crc_q <= 8'd0;
        end else if (send_accept) begin
            crc_q <= crc_next;
        end
    end
`endif

    // Output byte stream decode from state and byte index.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        tx_data  = 8'd0;
        tx_valid = 1'b0;
        tx_sof   = 1'b0;
        tx_eof   = 1'b0;
        case (state)
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = frame_bytes[rev_idx];
                tx_sof   = (byte_idx == 7'd0);
`ifdef FRAME_SERIALIZER_CRC_EN
                tx_eof   = 1'b0;
`else
                tx_eof   = at_last;
`endif
            end
`ifdef FRAME_SERIALIZER_CRC_EN
            ST_CRC: begin
                tx_valid = 1'b1;
                tx_data  = crc_q;
                tx_eof   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Main FSM: IDLE -> SEND [-> CRC] -> GAP/IDLE.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            // NOTE: sequential state uses non-blocking assignments only, so all
            // registers sample the same pre-edge values.
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_valid) state <= ST_SEND;
                end
                ST_SEND: begin
`ifdef FRAME_SERIALIZER_CRC_EN
                    if (send_accept && at_last) state <= ST_CRC;
`else
                    if (frame_done) state <= AFTER_FRAME;
`endif
                end
`ifdef FRAME_SERIALIZER_CRC_EN
                ST_CRC: begin
                    if (frame_done) state <= AFTER_FRAME;
                end
`endif
                ST_GAP: begin
                    if (gap_cnt == 8'd0) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Frame capture register, loaded only in IDLE.
    always_ff @(posedge clk) begin
        // NOTE: no reset on this wide data register; tx_data is gated by the
        // FSM state, so stale contents are never visible.
        if (capture) begin
            frame_q <= frame_in;
        end
    end

    // Byte index: cleared on capture, advances on each accepted frame byte.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            byte_idx <= 7'd0;
        end else if (capture) begin
            byte_idx <= 7'd0;
`ifdef FRAME_SERIALIZER_CRC_EN
        end else if (send_accept) begin
            byte_idx <= byte_idx + 7'd1;
`else
        end else if (send_accept && !at_last) begin
            byte_idx <= byte_idx + 7'd1;
`endif
        end
    end

    // Gap countdown loaded when the last byte of a frame is accepted.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            gap_cnt <= 8'd0;
        end else if (frame_done) begin
            gap_cnt <= GAP_INIT;
        end else if (state == ST_GAP && gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
        end
    end

    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt <= 16'd0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: directed, scoreboard-based bench for frame_serializer
// (GAP_CYCLES=4). Expected bytes are queued when a frame is driven and
// compared on each accepted byte. Define FRAME_SERIALIZER_CRC_EN for both
// the RTL and this bench to exercise the CRC byte.
module tb_frame_serializer;
    import frame_pkg::*;

    localparam int GAP = 4;
`ifdef FRAME_SERIALIZER_CRC_EN
    localparam int NB = NUM_BYTES + 1;
`else
    localparam int NB = NUM_BYTES;
`endif

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic [7:0] data;
    } exp_t;

    logic               clk;
    logic               resetN;
    logic [FRAME_W-1:0] frame_in;
    logic               frame_valid;
    logic               frame_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               tx_sof;
    logic               tx_eof;
    logic               busy;
    logic [15:0]        frame_cnt;

    int   errors = 0;
    int   checks = 0;
    int   acc_cnt = 0;
    int   exp_frames = 0;
    exp_t sb[$];
    exp_t mon_e;

    frame_serializer #(.GAP_CYCLES(GAP)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_sof      (tx_sof),
        .tx_eof      (tx_eof),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte k of a frame, written as a right shift rather than a part select.
    function automatic logic [7:0] model_byte(input logic [FRAME_W-1:0] f, input int k);
        logic [FRAME_W-1:0] s;
        if (k < NUM_BYTES - 1) begin
            s = f >> (FRAME_W - 8 - 8 * k);
            return s[7:0];
        end
        return {f[1:0], 6'b0};
    endfunction

`ifdef FRAME_SERIALIZER_CRC_EN
    // Bit-serial CRC-8 reference (poly from frame_pkg).
    function automatic logic [7:0] model_crc(input logic [7:0] crc, input logic [7:0] d);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb  = crc[7] ^ d[i];
            crc = {crc[6:0], 1'b0};
            if (fb) crc = crc ^ CRC8_POLY;
        end
        return crc;
    endfunction
`endif

    task automatic push_list(input logic [7:0] b [NUM_BYTES]);
        logic [7:0] crc;
        crc = 8'd0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            sb.push_back('{sof: (k == 0), eof: (k == NB - 1), data: b[k]});
`ifdef FRAME_SERIALIZER_CRC_EN
            crc = model_crc(crc, b[k]);
`endif
        end
`ifdef FRAME_SERIALIZER_CRC_EN
        sb.push_back('{sof: 1'b0, eof: 1'b1, data: crc});
`endif
    endtask

    task automatic push_frame(input logic [FRAME_W-1:0] f);
        logic [7:0] b [NUM_BYTES];
        for (int k = 0; k < NUM_BYTES; k++) b[k] = model_byte(f, k);
        push_list(b);
    endtask

    function automatic logic [FRAME_W-1:0] rand_frame();
        logic [543:0] r;
        for (int i = 0; i < 17; i++) r[i*32 +: 32] = $urandom;
        return r[FRAME_W-1:0];
    endfunction

    // Present a frame in IDLE; checks the 1-cycle latency to the sof byte.
    task automatic send_frame(input logic [FRAME_W-1:0] f);
        frame_in    = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        check("first_valid", tx_valid, 1'b1);
        check("first_sof", tx_sof, 1'b1);
        check("busy_in_send", busy, 1'b1);
    endtask

    task automatic wait_acc(input string tag, input int target);
        int n = 0;
        while (acc_cnt < target && n < 2000) begin
            tick();
            n++;
        end
        check(tag, acc_cnt, target);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!frame_ready && n < 100) begin
            tick();
            n++;
        end
        check(tag, frame_ready, 1'b1);
    endtask

    // Scoreboard: compare every byte the downstream accepts.
    always @(negedge clk) begin
        if (resetN && tx_valid && tx_ready) begin
            check("sb_has_entry", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("tx_byte", {tx_sof, tx_eof, tx_data}, mon_e);
            end
            acc_cnt++;
        end
    end

    initial begin
        logic [FRAME_W-1:0] f1, f2, f4, f5, f6, f7;
        logic [7:0]         b1 [NUM_BYTES];
        int                 base;
        int                 n;

        resetN      = 1'b0;
        frame_valid = 1'b0;
        frame_in    = '0;
        tx_ready    = 1'b1;

        // Reset held with the clock running.
        repeat (3) tick();
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'd0);
        check("rst_frame_cnt", frame_cnt, 16'd0);
        check("rst_frame_ready", frame_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        resetN = 1'b1;
        tick();

        // Single frame with the listed byte values.
        f1 = {512'h2AA, 8'hCC, 8'h33, 8'hF0, 2'b10};
        for (int k = 0; k < NUM_BYTES; k++) b1[k] = 8'h00;
        b1[62] = 8'h02; b1[63] = 8'hAA; b1[64] = 8'hCC;
        b1[65] = 8'h33; b1[66] = 8'hF0; b1[67] = 8'h80;
        base = acc_cnt;
        push_list(b1);
        send_frame(f1);
        wait_acc("f1_done", base + NB);
        exp_frames++;
        check("f1_frame_cnt", frame_cnt, exp_frames);
        check("f1_sb_empty", sb.size(), 0);
        wait_idle("f1_idle");

        // Backpressure at byte 5, ignored frame at byte 20, then the gap.
        f2 = rand_frame();
        base = acc_cnt;
        push_frame(f2);
        send_frame(f2);
        wait_acc("bp_reach", base + 5);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_data", tx_data, model_byte(f2, 5));
            check("bp_hold_flags", {tx_valid, tx_sof, tx_eof}, 3'b100);
            tick();
        end
        tx_ready = 1'b1;
        wait_acc("ign_reach", base + 20);
        frame_in    = ~f2;
        frame_valid = 1'b1;
        check("ign_ready_low", frame_ready, 1'b0);
        repeat (3) tick();
        frame_valid = 1'b0;
        wait_acc("f2_done", base + NB);
        for (int i = 0; i < GAP; i++) begin
            check("gap_ready_low", frame_ready, 1'b0);
            check("gap_no_valid", tx_valid, 1'b0);
            tick();
        end
        check("gap_end_ready", frame_ready, 1'b1);
        exp_frames++;
        check("f2_frame_cnt", frame_cnt, exp_frames);
        check("f2_sb_empty", sb.size(), 0);

        // Back-to-back frames with frame_valid held: gap plus one IDLE cycle.
        f4 = rand_frame();
        f5 = rand_frame();
        base = acc_cnt;
        push_frame(f4);
        push_frame(f5);
        frame_in    = f4;
        frame_valid = 1'b1;
        tick();
        frame_in = f5;
        wait_acc("b2b_first", base + NB);
        n = 0;
        while (!tx_sof && n < 50) begin
            tick();
            n++;
        end
        check("b2b_idle_cycles", n, GAP + 1);
        frame_valid = 1'b0;
        wait_acc("b2b_second", base + 2 * NB);
        exp_frames += 2;
        check("b2b_frame_cnt", frame_cnt, exp_frames);
        wait_idle("b2b_idle");

        // Asynchronous reset mid-frame at byte 30.
        f6 = rand_frame();
        base = acc_cnt;
        push_frame(f6);
        send_frame(f6);
        wait_acc("rst_reach", base + 30);
        #2;
        resetN = 1'b0;
        #1;
        check("async_tx_valid", tx_valid, 1'b0);
        check("async_tx_data", tx_data, 8'd0);
        check("async_flags", {tx_sof, tx_eof, busy}, 3'b000);
        check("async_frame_ready", frame_ready, 1'b1);
        check("async_frame_cnt", frame_cnt, 16'd0);
        sb.delete();
        exp_frames = 0;
        @(posedge clk);
        #3;
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_quiet", tx_valid, 1'b0);
        end
        f7 = rand_frame();
        base = acc_cnt;
        push_frame(f7);
        send_frame(f7);
        wait_acc("f7_done", base + NB);
        exp_frames++;
        check("f7_frame_cnt", frame_cnt, exp_frames);
        wait_idle("f7_idle");

`ifdef FRAME_SERIALIZER_CRC_EN
        // All-zero frame: CRC byte must be 0x00 with eof.
        base = acc_cnt;
        push_frame('0);
        send_frame('0);
        wait_acc("zero_done", base + NB);
        exp_frames++;
        check("zero_frame_cnt", frame_cnt, exp_frames);
        wait_idle("zero_idle");
`endif

        check("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
